spi_reg_bank: RTL

Parametrised SPI-slave register bank: an external SPI master (mode 0, MSB first) writes a bank of N_WR 8-bit control registers and reads a bank of N_RD 8-bit status bytes through one addressed, auto-incrementing protocol. A command byte gives direction and start address. Writes produce per-register one-cycle strobes for the PWM/control logic. Reads are served from a coherent snapshot of the status inputs taken once per frame. Sits between the board SPI pins and the fabric registers, all in the CLK domain.

---
 rtl/spi_reg_pkg.sv | 20 ++
 rtl/spi_byte_shifter.sv | 128 ++++++++++++
 rtl/spi_reg_bank.sv | 135 +++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared constants and the frame FSM state type for the SPI
// register bank.
//   CMD_RD_BIT  : command-byte bit that selects read (1) or write (0)
//   ADDR_W      : width of the auto-incrementing register address
//   SYNC_STAGES : flop count of each pin synchroniser
//   state_e     : frame FSM states
package spi_reg_pkg;

  localparam int CMD_RD_BIT  = 7;
  localparam int ADDR_W      = 7;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: pin synchronisers, SCLK/CS edge detection, bit counter
// and rx/tx shift registers for an SPI mode-0 slave (MSB first).
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   cs_pin, sclk_pin,
//   mosi_pin            : raw asynchronous SPI pins
//   load, tx_byte       : load tx_byte into the tx shifter on this edge
//   miso                : tx shifter MSB (0 outside an active frame)
//   busy                : synchronised CS asserted
//   byte_done, rx_byte  : one-cycle pulse after the 8th SCLK rise; rx_byte
//                         holds the received byte while byte_done is high
//   frame_start         : one-cycle pulse on an accepted CS fall
//   frame_end           : one-cycle pulse on CS rise of an active frame,
//                         aligned so that a final byte_done can coincide
//   frame_err           : one-cycle pulse when a frame ends mid-byte
//
// Handshake: load/tx_byte is a single-cycle request from the parent and is
// accepted unconditionally while a frame is active; there is no back-pressure.
module spi_byte_shifter
  import spi_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_pin,
  input  logic       sclk_pin,
  input  logic       mosi_pin,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       miso,
  output logic       busy,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] settle;
  logic                   cs_q;
  logic                   sclk_q;
  logic                   need_idle;
  logic                   armed;
  logic [2:0]             bit_cnt;
  logic [2:0]             cnt_next;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;
  logic settled;
  logic accept_fall;

  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign cs_fall     = ~cs_s & cs_q;
  assign cs_rise     = cs_s & ~cs_q;
  assign settled     = settle[SYNC_STAGES-1];
  // After reset the CS chain restarts from "deasserted"; a fall seen before
  // the chain has shown a genuine high is a leftover of the interrupted frame.
  assign accept_fall = cs_fall & ~need_idle;
  assign cnt_next    = sclk_rise ? bit_cnt + 3'd1 : bit_cnt;

  assign miso    = tx_shift[7];
  assign busy    = ~cs_s;
  assign rx_byte = rx_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync     <= '1;
      sclk_sync   <= '0;
      mosi_sync   <= '0;
      settle      <= '0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      need_idle   <= 1'b1;
      armed       <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      byte_done   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
      settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
      cs_q      <= cs_s;
      sclk_q    <= sclk_s;

      if (settled && cs_s) need_idle <= 1'b0;

      frame_start <= accept_fall;
      frame_end   <= cs_rise & armed;
      // An SCLK rise in the CS-rise cycle still counts, so a byte that
      // completes exactly there is not an error.
      frame_err   <= cs_rise & armed & (cnt_next != 3'd0);
      byte_done   <= armed & sclk_rise & (bit_cnt == 3'd7);

      if (accept_fall)  armed <= 1'b1;
      else if (cs_rise) armed <= 1'b0;

      if (!armed)         bit_cnt <= 3'd0;
      else if (sclk_rise) bit_cnt <= cnt_next;

      if (armed && sclk_rise) rx_shift <= {rx_shift[6:0], mosi_s};

      // The fall right after a byte boundary is not shifted: the freshly
      // loaded MSB must stay on MISO for the next byte's first rise.
      if (!armed)                            tx_shift <= 8'h00;
      else if (load)                         tx_shift <= tx_byte;
      else if (sclk_fall && bit_cnt != 3'd0) tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-slave register bank. A command byte (bit7 read/write,
// bits6:0 start address) is followed by auto-incrementing data bytes.
// Writes update N_WR control registers with one-cycle strobes; reads return
// a snapshot of the N_RD status bytes taken at the end of the command byte.
// Ports:
//   CLK, RST          : system clock (>= 8x SCLK), synchronous active-high reset
//   CS, SCLK, MOSI    : asynchronous SPI pins (mode 0, MSB first)
//   MISO              : SPI data out, 0 while CS is high
//   WR_DATA / WR_STB  : register i at [8i+7:8i], one-cycle strobe on write
//   RD_DATA           : status byte j at [8j+7:8j]
//   BUSY              : synchronised CS asserted
//   FRAME_ERR         : one-cycle pulse when a frame ends with a partial byte
//   DBG_STATE         : current frame FSM state (state_e encoding)
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int N_WR = 6,
  parameter int N_RD = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic [8*N_WR-1:0] WR_DATA,
  output logic [N_WR-1:0]   WR_STB,
  input  logic [8*N_RD-1:0] RD_DATA,
  output logic              BUSY,
  output logic              FRAME_ERR,
  output logic [1:0]        DBG_STATE
);

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        wr_q [N_WR];
  logic [7:0]        snap [N_RD];
  logic              byte_done;
  logic [7:0]        rx_byte;
  logic              frame_start;
  logic              frame_end;
  logic              load;
  logic [7:0]        tx_byte;
  logic              cmd_rd;
  logic [ADDR_W-1:0] cmd_addr;
  logic              wr_en;

  assign cmd_rd    = rx_byte[CMD_RD_BIT];
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  assign wr_en     = (state == WR) && byte_done && (int'(addr) < N_WR);
  assign DBG_STATE = state;

  spi_byte_shifter u_shifter (
    .clk         (CLK),
    .rst         (RST),
    .cs_pin      (CS),
    .sclk_pin    (SCLK),
    .mosi_pin    (MOSI),
    .load        (load),
    .tx_byte     (tx_byte),
    .miso        (MISO),
    .busy        (BUSY),
    .byte_done   (byte_done),
    .rx_byte     (rx_byte),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_err   (FRAME_ERR)
  );

  // Next-state and shifter-load decode. rd_addr is the address whose status
  // byte is handed to the shifter when load is raised.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rd_addr   = ADDR_W'(addr + 1'b1);
    case (state)
      IDLE: if (frame_start) state_nxt = CMD;
      CMD: begin
        if (byte_done) begin
          state_nxt = cmd_rd ? RD : WR;
          load      = cmd_rd;
          rd_addr   = cmd_addr;
        end
      end
      WR: ;
      RD: if (byte_done) load = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // A byte completing together with CS rise is still processed above.
    if (frame_end) state_nxt = IDLE;
  end

  // The first read byte comes straight from RD_DATA because the snapshot is
  // captured on that same edge; later bytes come from the snapshot.
  always_comb begin
    tx_byte = 8'h00;
    for (int j = 0; j < N_RD; j++) begin
      if (rd_addr == ADDR_W'(j)) tx_byte = (state == CMD) ? RD_DATA[8*j +: 8] : snap[j];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      addr   <= '0;
      WR_STB <= '0;
      for (int i = 0; i < N_WR; i++) wr_q[i] <= 8'h00;
      for (int j = 0; j < N_RD; j++) snap[j] <= 8'h00;
    end else begin
      state  <= state_nxt;
      WR_STB <= '0;

      if (state == CMD && byte_done)                      addr <= cmd_addr;
      else if ((state == WR || state == RD) && byte_done) addr <= ADDR_W'(addr + 1'b1);

      for (int i = 0; i < N_WR; i++) begin
        if (wr_en && addr == ADDR_W'(i)) begin
          wr_q[i]   <= rx_byte;
          WR_STB[i] <= 1'b1;
        end
      end

      if (state == CMD && byte_done && cmd_rd) begin
        for (int j = 0; j < N_RD; j++) snap[j] <= RD_DATA[8*j +: 8];
      end
    end
  end

  for (genvar g = 0; g < N_WR; g++) begin : g_wr_out
    assign WR_DATA[8*g +: 8] = wr_q[g];
  end

endmodule
